// File: rtl/reg_write_queue_pkg.sv
// rtl/reg_write_queue_pkg.sv - shared packed register-write layout and helpers
package reg_write_queue_pkg;

    localparam int NUM_REGS    = 32;
    localparam int RW_ADDR_W   = $clog2(NUM_REGS);
    localparam int RW_DATA_W   = 16;
    localparam int RW_WIDTH    = RW_ADDR_W + RW_DATA_W;
    localparam int RW_ADDR_MSB = RW_WIDTH - 1;
    localparam int RW_ADDR_LSB = RW_DATA_W;
    localparam int RW_DATA_MSB = RW_DATA_W - 1;
    localparam int RW_DATA_LSB = 0;

    typedef logic [RW_WIDTH-1:0]  reg_write_t;
    typedef logic [RW_ADDR_W-1:0] reg_addr_t;
    typedef logic [RW_DATA_W-1:0] reg_data_t;

    function automatic reg_addr_t rw_addr(input reg_write_t w);
        return w[RW_ADDR_MSB:RW_ADDR_LSB];
    endfunction

    function automatic reg_data_t rw_data(input reg_write_t w);
        return w[RW_DATA_MSB:RW_DATA_LSB];
    endfunction

    function automatic reg_write_t rw_pack(input reg_addr_t a, input reg_data_t d);
        return {a, d};
    endfunction

endpackage

// File: rtl/reg_write_queue_if.sv
// rtl/reg_write_queue_if.sv - producer, register-file and hazard-check signals of the write queue
interface reg_write_queue_if
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic                     iResultValid1;
    logic                     iResultValid2;
    reg_write_t               iResult1;
    reg_write_t               iResult2;
    logic                     oResultReady1;
    logic                     oResultReady2;
    logic                     iStall;
    logic                     oWritePort1;
    logic                     oWritePort2;
    reg_write_t               oRegWrite1;
    reg_write_t               oRegWrite2;
    reg_addr_t                iCheckSel;
    logic                     oCheckHit;
    logic [$clog2(DEPTH):0]   oLevel;

    modport slave (
        input  iResultValid1, iResultValid2, iResult1, iResult2, iStall, iCheckSel,
        output oResultReady1, oResultReady2, oWritePort1, oWritePort2,
               oRegWrite1, oRegWrite2, oCheckHit, oLevel
    );

    modport master (
        output iResultValid1, iResultValid2, iResult1, iResult2, iStall, iCheckSel,
        input  oResultReady1, oResultReady2, oWritePort1, oWritePort2,
               oRegWrite1, oRegWrite2, oCheckHit, oLevel
    );
endinterface

// File: rtl/reg_write_queue_fifo.sv
// rtl/reg_write_queue_fifo.sv - two-in/two-out circular store with per-entry valid bits
module reg_write_fifo
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push1,
    input  logic                          i_push2,
    input  reg_write_t                    i_data1,
    input  reg_write_t                    i_data2,
    input  logic [1:0]                    i_pop_cnt,
    output reg_write_t                    o_head0,
    output reg_write_t                    o_head1,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [DEPTH-1:0]              o_valid,
    output reg_write_t [DEPTH-1:0]        o_entries
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reg_write_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [DEPTH-1:0]       r_valid;

    logic [PTR_W-1:0]       w_wr_idx2;
    logic [PTR_W-1:0]       w_rd_idx1;
    logic [DEPTH-1:0]       w_valid_next;

    // Slot 2 lands directly behind slot 1 only when slot 1 was actually enqueued.
    assign w_wr_idx2 = r_wr_ptr + PTR_W'(i_push1);
    assign w_rd_idx1 = r_rd_ptr + PTR_W'(1);

    always_comb begin
        w_valid_next = r_valid;
        if (i_pop_cnt != 2'd0) w_valid_next[r_rd_ptr]  = 1'b0;
        if (i_pop_cnt == 2'd2) w_valid_next[w_rd_idx1] = 1'b0;
        if (i_push1)           w_valid_next[r_wr_ptr]  = 1'b1;
        if (i_push2)           w_valid_next[w_wr_idx2] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_cnt);
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push1) + PTR_W'(i_push2);
            r_count  <= r_count + CNT_W'(i_push1) + CNT_W'(i_push2) - CNT_W'(i_pop_cnt);
            r_valid  <= w_valid_next;
        end
    end

    // Payload needs no reset: every consumer qualifies it with count or valid bits.
    always_ff @(posedge i_clk) begin
        if (i_push1) r_mem[r_wr_ptr]  <= i_data1;
        if (i_push2) r_mem[w_wr_idx2] <= i_data2;
    end

    assign o_head0   = r_mem[r_rd_ptr];
    assign o_head1   = r_mem[w_rd_idx1];
    assign o_count   = r_count;
    assign o_valid   = r_valid;
    assign o_entries = r_mem;

endmodule

// File: rtl/reg_write_queue.sv
// rtl/reg_write_queue.sv - dual-slot result queue feeding two register-file write ports
module reg_write_queue
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic             iClock,
    input  logic             iReset,
    reg_write_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   w_ready1;
    logic                   w_ready2;
    logic                   w_push1;
    logic                   w_push2;
    logic                   w_wp1;
    logic                   w_wp2;
    logic [1:0]             w_pop_cnt;
    logic                   w_hit;
    reg_write_t             w_head0;
    reg_write_t             w_head1;
    logic [CNT_W-1:0]       w_count;
    logic [DEPTH-1:0]       w_valid;
    reg_write_t [DEPTH-1:0] w_entries;

    // Space is judged on the registered count only, so a same-cycle drain never frees room.
    assign w_ready1 = (w_count <= CNT_W'(DEPTH - 1));
    assign w_ready2 = (w_count <= CNT_W'(DEPTH - 2));

    assign w_push1 = bus.iResultValid1 && w_ready1 && (rw_addr(bus.iResult1) != '0);
    assign w_push2 = bus.iResultValid2 && w_ready2 && (rw_addr(bus.iResult2) != '0);

    // A same-address pair is split across cycles so the later write wins in the register file.
    assign w_wp1 = (w_count != '0) && !bus.iStall;
    assign w_wp2 = (w_count >= CNT_W'(2)) && !bus.iStall
                   && (rw_addr(w_head1) != rw_addr(w_head0));
    assign w_pop_cnt = {1'b0, w_wp1} + {1'b0, w_wp2};

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (rw_addr(w_entries[i]) == bus.iCheckSel)) w_hit = 1'b1;
        end
    end

    reg_write_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .i_clk     (iClock),
        .i_rst     (iReset),
        .i_push1   (w_push1),
        .i_push2   (w_push2),
        .i_data1   (bus.iResult1),
        .i_data2   (bus.iResult2),
        .i_pop_cnt (w_pop_cnt),
        .o_head0   (w_head0),
        .o_head1   (w_head1),
        .o_count   (w_count),
        .o_valid   (w_valid),
        .o_entries (w_entries)
    );

    assign bus.oResultReady1 = w_ready1;
    assign bus.oResultReady2 = w_ready2;
    assign bus.oWritePort1   = w_wp1;
    assign bus.oWritePort2   = w_wp2;
    assign bus.oRegWrite1    = w_wp1 ? w_head0 : '0;
    assign bus.oRegWrite2    = w_wp2 ? w_head1 : '0;
    assign bus.oCheckHit     = w_hit && (bus.iCheckSel != '0);
    assign bus.oLevel        = w_count;

endmodule

// File: tb/tb_reg_write_queue.sv
// tb/tb_reg_write_queue.sv - scoreboard bench for reg_write_queue
module tb_reg_write_queue;
    localparam int DEPTH = 8;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [20:0] sb[$];

    reg_write_queue_if #(.DEPTH(DEPTH)) bus ();

    reg_write_queue #(.DEPTH(DEPTH)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus.slave)
    );

    always #5 iClock = ~iClock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic v1, input logic [20:0] d1, input logic v2,
                         input logic [20:0] d2, input logic stall, input logic [4:0] sel);
        bus.iResultValid1 = v1;
        bus.iResult1      = d1;
        bus.iResultValid2 = v2;
        bus.iResult2      = d2;
        bus.iStall        = stall;
        bus.iCheckSel     = sel;
    endtask

    // Model checks the current cycle, then applies this edge's dequeues and enqueues.
    task automatic run_cycle();
        int          n;
        logic        e_r1, e_r2, e_w1, e_w2, e_hit;
        logic [20:0] q0, q1, e_rw1, e_rw2;
        #1;
        n  = sb.size();
        q0 = (n >= 1) ? sb[0] : 21'h0;
        q1 = (n >= 2) ? sb[1] : 21'h0;
        e_r1  = (n <= DEPTH - 1);
        e_r2  = (n <= DEPTH - 2);
        e_w1  = (n >= 1) && !bus.iStall;
        e_w2  = (n >= 2) && !bus.iStall && (q0[20:16] != q1[20:16]);
        e_rw1 = e_w1 ? q0 : 21'h0;
        e_rw2 = e_w2 ? q1 : 21'h0;
        e_hit = 1'b0;
        foreach (sb[i]) if (sb[i][20:16] == bus.iCheckSel && bus.iCheckSel != 5'd0) e_hit = 1'b1;
        check_eq("ready1",   32'(bus.oResultReady1), 32'(e_r1));
        check_eq("ready2",   32'(bus.oResultReady2), 32'(e_r2));
        check_eq("wport1",   32'(bus.oWritePort1),   32'(e_w1));
        check_eq("wport2",   32'(bus.oWritePort2),   32'(e_w2));
        check_eq("regwr1",   32'(bus.oRegWrite1),    32'(e_rw1));
        check_eq("regwr2",   32'(bus.oRegWrite2),    32'(e_rw2));
        check_eq("level",    32'(bus.oLevel),        32'(n));
        check_eq("checkhit", 32'(bus.oCheckHit),     32'(e_hit));
        if (e_w1) void'(sb.pop_front());
        if (e_w2) void'(sb.pop_front());
        if (bus.iResultValid1 && e_r1 && bus.iResult1[20:16] != 5'd0) sb.push_back(bus.iResult1);
        if (bus.iResultValid2 && e_r2 && bus.iResult2[20:16] != 5'd0) sb.push_back(bus.iResult2);
        @(posedge iClock);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) run_cycle();
        check_eq("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge iClock);
        #1;
        check_eq("rst_level",  32'(bus.oLevel),      32'd0);
        check_eq("rst_wport1", 32'(bus.oWritePort1), 32'd0);
        check_eq("rst_regwr1", 32'(bus.oRegWrite1),  32'd0);
        check_eq("rst_hit",    32'(bus.oCheckHit),   32'd0);
        iReset = 1'b0;
        run_cycle();

        // Single result, one-cycle latency.
        drive(1, 21'h051234, 0, 0, 0, 0);
        run_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_eq("t1_wport1", 32'(bus.oWritePort1), 32'd1);
        check_eq("t1_regwr1", 32'(bus.oRegWrite1),  32'h051234);
        run_cycle();
        check_eq("t1_level",  32'(bus.oLevel),      32'd0);

        // Same-address pair splits across two cycles.
        drive(1, 21'h03AAAA, 1, 21'h03BBBB, 0, 0);
        run_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_eq("t2_c2_wport2", 32'(bus.oWritePort2), 32'd0);
        check_eq("t2_c2_regwr1", 32'(bus.oRegWrite1),  32'h03AAAA);
        run_cycle();
        check_eq("t2_c3_regwr1", 32'(bus.oRegWrite1),  32'h03BBBB);
        run_cycle();

        // Fill under stall, then drain two per cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1, {5'(2 * k + 1), 16'($urandom)}, 1, {5'(2 * k + 2), 16'($urandom)}, 1, 0);
            run_cycle();
        end
        drive(0, 0, 0, 0, 1, 0);
        #1;
        check_eq("t3_full_level",  32'(bus.oLevel),        32'd8);
        check_eq("t3_full_ready1", 32'(bus.oResultReady1), 32'd0);
        check_eq("t3_full_ready2", 32'(bus.oResultReady2), 32'd0);
        run_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            #1;
            check_eq("t3_dual_write", 32'({bus.oWritePort1, bus.oWritePort2}), 32'd3);
            run_cycle();
        end
        check_eq("t3_empty", 32'(bus.oLevel), 32'd0);

        // Address 0 is consumed without enqueuing.
        drive(1, 21'h005555, 0, 0, 0, 0);
        run_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_eq("t4_level",  32'(bus.oLevel),      32'd0);
        check_eq("t4_wport1", 32'(bus.oWritePort1), 32'd0);
        run_cycle();

        // Pending-write hazard check.
        drive(1, 21'h090001, 0, 0, 1, 9);
        run_cycle();
        drive(0, 0, 0, 0, 1, 9);
        #1;
        check_eq("t5_hit9", 32'(bus.oCheckHit), 32'd1);
        bus.iCheckSel = 5'd10;
        #1;
        check_eq("t5_hit10", 32'(bus.oCheckHit), 32'd0);
        run_cycle();
        drain();

        // Random traffic with collisions, zero addresses and stalls.
        for (int k = 0; k < 80; k++) begin
            drive(1'($urandom_range(0, 1)), {5'($urandom_range(0, 7)), 16'($urandom)},
                  1'($urandom_range(0, 1)), {5'($urandom_range(0, 7)), 16'($urandom)},
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            run_cycle();
        end
        drain();

        // Asynchronous reset with five entries queued.
        drive(1, 21'h090009, 1, 21'h040004, 1, 0);
        run_cycle();
        drive(1, 21'h060006, 1, 21'h070007, 1, 0);
        run_cycle();
        drive(1, 21'h080008, 0, 0, 1, 0);
        run_cycle();
        check_eq("t6_level5", 32'(bus.oLevel), 32'd5);
        drive(0, 0, 0, 0, 1, 9);
        #2;
        iReset = 1'b1;
        sb.delete();
        #1;
        check_eq("t6_rst_level",  32'(bus.oLevel),    32'd0);
        check_eq("t6_rst_hit",    32'(bus.oCheckHit), 32'd0);
        bus.iStall = 1'b0;
        #1;
        check_eq("t6_rst_wport1", 32'(bus.oWritePort1), 32'd0);
        check_eq("t6_rst_regwr1", 32'(bus.oRegWrite1),  32'd0);
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        for (int k = 0; k < 3; k++) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
